// File: rtl/wb_arbiter2.sv
// Two-master / one-slave Wishbone classic arbiter.
// Round-robin grant that is held for the owner's whole cycle, plus a bus
// watchdog that terminates a stalled strobe with err on the owner side.
module wb_arbiter2 #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [3:0]  m0_sel_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    output logic        m0_rty_o,

    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [3:0]  m1_sel_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic        m1_rty_o,

    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    output logic [31:0] s_adr_o,
    output logic [3:0]  s_sel_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,
    input  logic        s_rty_i,

    output logic [1:0]  grant_o
);

    localparam int unsigned TW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_MAX  = '1;
    localparam bit            TMO_EN   = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state;
    state_t        state_n;
    logic          last;
    logic          last_n;
    logic [TW-1:0] tmo_cnt;
    logic [TW-1:0] tmo_n;
    logic          own_stb;
    logic          term;
    logic          fire;

    // State, last-owner and watchdog registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= IDLE;
            last    <= 1'b1;
            tmo_cnt <= '0;
        end else begin
            state   <= state_n;
            last    <= last_n;
            tmo_cnt <= tmo_n;
        end
    end

    // Arbitration and release: ties go to the master that did not own last
    always_comb begin
        state_n = state;
        last_n  = last;
        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_n = last ? OWN0 : OWN1;
                end else if (m0_cyc_i) begin
                    state_n = OWN0;
                end else if (m1_cyc_i) begin
                    state_n = OWN1;
                end
            end
            OWN0: begin
                if (!m0_cyc_i) begin
                    last_n  = 1'b0;
                    state_n = m1_cyc_i ? OWN1 : IDLE;
                end
            end
            OWN1: begin
                if (!m1_cyc_i) begin
                    last_n  = 1'b1;
                    state_n = m0_cyc_i ? OWN0 : IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Watchdog: count unterminated owner strobe cycles, fire on the last one
    always_comb begin
        own_stb = ((state == OWN0) && m0_stb_i) || ((state == OWN1) && m1_stb_i);
        term    = s_ack_i | s_err_i | s_rty_i;
        fire    = 1'b0;
        if (TMO_EN) begin
            fire = own_stb && !term && (tmo_cnt == TMO_LAST);
        end
        tmo_n = '0;
        if (own_stb && !term && !fire) begin
            tmo_n = (tmo_cnt == TMO_MAX) ? tmo_cnt : tmo_cnt + 1'b1;
        end
    end

    // Combinational routing between the owner and the slave; all zero in IDLE
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_sel_o  = '0;
        s_dat_o  = '0;
        m0_dat_o = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m0_rty_o = 1'b0;
        m1_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m1_rty_o = 1'b0;
        grant_o  = 2'b00;
        case (state)
            OWN0: begin
                grant_o  = 2'b01;
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i & ~fire;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_sel_o  = m0_sel_i;
                s_dat_o  = m0_dat_i;
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i & m0_stb_i;
                m0_err_o = (s_err_i & m0_stb_i) | fire;
                m0_rty_o = s_rty_i & m0_stb_i;
            end
            OWN1: begin
                grant_o  = 2'b10;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i & ~fire;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_sel_o  = m1_sel_i;
                s_dat_o  = m1_dat_i;
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i & m1_stb_i;
                m1_err_o = (s_err_i & m1_stb_i) | fire;
                m1_rty_o = s_rty_i & m1_stb_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Testbench for wb_arbiter2: directed scenarios plus randomized traffic
// compared against a behavioural owner/age model of the arbiter.
module tb_wb_arbiter2;

    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
    logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, s_dat_i;
    logic [3:0]  m0_sel, m1_sel;
    logic        s_ack, s_err, s_rty;

    logic [31:0] a_m0_dat, a_m1_dat, a_s_adr, a_s_dat;
    logic        a_m0_ack, a_m0_err, a_m0_rty, a_m1_ack, a_m1_err, a_m1_rty;
    logic        a_s_cyc, a_s_stb, a_s_we;
    logic [3:0]  a_s_sel;
    logic [1:0]  a_grant;

    logic [31:0] b_m0_dat, b_m1_dat, b_s_adr, b_s_dat;
    logic        b_m0_ack, b_m0_err, b_m0_rty, b_m1_ack, b_m1_err, b_m1_rty;
    logic        b_s_cyc, b_s_stb, b_s_we;
    logic [3:0]  b_s_sel;
    logic [1:0]  b_grant;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_arbiter2 #(.TIMEOUT_CYCLES(TMO)) dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
        .m0_sel_i(m0_sel), .m0_dat_i(m0_dat), .m0_dat_o(a_m0_dat),
        .m0_ack_o(a_m0_ack), .m0_err_o(a_m0_err), .m0_rty_o(a_m0_rty),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
        .m1_sel_i(m1_sel), .m1_dat_i(m1_dat), .m1_dat_o(a_m1_dat),
        .m1_ack_o(a_m1_ack), .m1_err_o(a_m1_err), .m1_rty_o(a_m1_rty),
        .s_cyc_o(a_s_cyc), .s_stb_o(a_s_stb), .s_we_o(a_s_we), .s_adr_o(a_s_adr),
        .s_sel_o(a_s_sel), .s_dat_o(a_s_dat), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty), .grant_o(a_grant)
    );

    wb_arbiter2 #(.TIMEOUT_CYCLES(0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
        .m0_sel_i(m0_sel), .m0_dat_i(m0_dat), .m0_dat_o(b_m0_dat),
        .m0_ack_o(b_m0_ack), .m0_err_o(b_m0_err), .m0_rty_o(b_m0_rty),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
        .m1_sel_i(m1_sel), .m1_dat_i(m1_dat), .m1_dat_o(b_m1_dat),
        .m1_ack_o(b_m1_ack), .m1_err_o(b_m1_err), .m1_rty_o(b_m1_rty),
        .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb), .s_we_o(b_s_we), .s_adr_o(b_s_adr),
        .s_sel_o(b_s_sel), .s_dat_o(b_s_dat), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack), .s_err_i(s_err), .s_rty_i(s_rty), .grant_o(b_grant)
    );

    // Reference model: owner (-1 = nobody), previous owner, and how many
    // consecutive unterminated strobe cycles the owner has accumulated.
    int mdl_owner, mdl_last, mdl_age;

    function automatic bit model_fire(input int owner, input int age, input bit stb, input bit t);
        return (TMO > 0) && (owner >= 0) && stb && !t && (age + 1 == TMO);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int  nxt_owner, nxt_last, nxt_age;
        bit  stb_now, cyc_now, other_cyc, t;
        if (!rst_n) begin
            mdl_owner <= -1;
            mdl_last  <= 1;
            mdl_age   <= 0;
        end else begin
            nxt_owner = mdl_owner;
            nxt_last  = mdl_last;
            t         = s_ack | s_err | s_rty;
            stb_now   = (mdl_owner == 0) ? m0_stb : (mdl_owner == 1) ? m1_stb : 1'b0;
            if (stb_now && !t && !model_fire(mdl_owner, mdl_age, stb_now, t))
                nxt_age = mdl_age + 1;
            else
                nxt_age = 0;
            if (mdl_owner < 0) begin
                if (m0_cyc && m1_cyc) nxt_owner = 1 - mdl_last;
                else if (m0_cyc)      nxt_owner = 0;
                else if (m1_cyc)      nxt_owner = 1;
            end else begin
                cyc_now   = (mdl_owner == 0) ? m0_cyc : m1_cyc;
                other_cyc = (mdl_owner == 0) ? m1_cyc : m0_cyc;
                if (!cyc_now) begin
                    nxt_last  = mdl_owner;
                    nxt_owner = other_cyc ? 1 - mdl_owner : -1;
                end
            end
            mdl_owner <= nxt_owner;
            mdl_last  <= nxt_last;
            mdl_age   <= nxt_age;
        end
    end

    logic [1:0]  e_grant;
    logic        e_s_cyc, e_s_stb, e_s_we, e_fire;
    logic [31:0] e_s_adr, e_s_dat;
    logic [3:0]  e_s_sel;
    logic [31:0] e_dat [2];
    logic        e_ack [2];
    logic        e_err [2];
    logic        e_rty [2];
    logic        e_berr [2];
    logic        o_cyc, o_stb, o_we;
    logic [31:0] o_adr, o_dat;
    logic [3:0]  o_sel;

    // Expected outputs derived from the model state and current inputs
    always_comb begin
        e_grant = 2'b00; e_s_cyc = 1'b0; e_s_stb = 1'b0; e_s_we = 1'b0;
        e_s_adr = '0; e_s_sel = '0; e_s_dat = '0; e_fire = 1'b0;
        o_cyc = 1'b0; o_stb = 1'b0; o_we = 1'b0; o_adr = '0; o_sel = '0; o_dat = '0;
        for (int i = 0; i < 2; i++) begin
            e_dat[i] = '0; e_ack[i] = 1'b0; e_err[i] = 1'b0; e_rty[i] = 1'b0; e_berr[i] = 1'b0;
        end
        if (mdl_owner == 0 || mdl_owner == 1) begin
            o_cyc = (mdl_owner == 0) ? m0_cyc : m1_cyc;
            o_stb = (mdl_owner == 0) ? m0_stb : m1_stb;
            o_we  = (mdl_owner == 0) ? m0_we  : m1_we;
            o_adr = (mdl_owner == 0) ? m0_adr : m1_adr;
            o_sel = (mdl_owner == 0) ? m0_sel : m1_sel;
            o_dat = (mdl_owner == 0) ? m0_dat : m1_dat;
            e_fire  = model_fire(mdl_owner, mdl_age, o_stb, s_ack | s_err | s_rty);
            e_grant = (mdl_owner == 0) ? 2'b01 : 2'b10;
            e_s_cyc = o_cyc;
            e_s_stb = o_stb & ~e_fire;
            e_s_we  = o_we;
            e_s_adr = o_adr;
            e_s_sel = o_sel;
            e_s_dat = o_dat;
            for (int i = 0; i < 2; i++) begin
                if (mdl_owner == i) begin
                    e_dat[i]  = s_dat_i;
                    e_ack[i]  = s_ack & o_stb;
                    e_err[i]  = (s_err & o_stb) | e_fire;
                    e_rty[i]  = s_rty & o_stb;
                    e_berr[i] = s_err & o_stb;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_sel = '0; m0_dat = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_sel = '0; m1_dat = '0;
        s_dat_i = '0; s_ack = 0; s_err = 0; s_rty = 0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
        s_ack = 1; s_dat_i = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++;
        if (a_grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", a_grant); end
        checks++;
        if ({a_s_cyc, a_s_stb, a_s_adr} !== 34'h0) begin
            errors++; $display("FAIL reset_slave: got cyc=%b stb=%b adr=%h expected all 0", a_s_cyc, a_s_stb, a_s_adr);
        end
        checks++;
        if ({a_m0_dat, a_m0_ack, a_m1_dat, a_m1_ack} !== 66'h0) begin
            errors++; $display("FAIL reset_masters: got m0=%h/%b m1=%h/%b expected 0", a_m0_dat, a_m0_ack, a_m1_dat, a_m1_ack);
        end
        tick();
        rst_n = 1'b1;
        idle_inputs();
    endtask

    task automatic test_single_write();
        apply_reset();
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h1000; m0_sel = 4'hF; m0_dat = 32'hA5;
        @(negedge clk);
        checks++;
        if ({a_grant, a_s_stb} !== 3'b000) begin
            errors++; $display("FAIL write_latency: got grant=%b stb=%b expected 00/0", a_grant, a_s_stb);
        end
        tick();
        s_ack = 1; s_dat_i = 32'h1234_5678;
        @(negedge clk);
        checks++;
        if (a_grant !== 2'b01) begin errors++; $display("FAIL write_grant: got %b expected 01", a_grant); end
        checks++;
        if ({a_s_stb, a_s_we, a_s_adr, a_s_dat} !== {2'b11, 32'h1000, 32'hA5}) begin
            errors++; $display("FAIL write_slave: got stb=%b we=%b adr=%h dat=%h expected 1 1 00001000 000000a5",
                               a_s_stb, a_s_we, a_s_adr, a_s_dat);
        end
        checks++;
        if (a_m0_ack !== 1'b1) begin errors++; $display("FAIL write_ack: got %b expected 1", a_m0_ack); end
        checks++;
        if ({a_m1_dat, a_m1_ack, a_m1_err, a_m1_rty} !== 35'h0) begin
            errors++; $display("FAIL write_m1_quiet: got dat=%h ack=%b err=%b rty=%b expected 0",
                               a_m1_dat, a_m1_ack, a_m1_err, a_m1_rty);
        end
        tick();
        m0_cyc = 0; m0_stb = 0; s_ack = 0;
        @(negedge clk);
        checks++;
        if ({a_grant, a_m0_ack} !== 3'b010) begin
            errors++; $display("FAIL write_ack_once: got grant=%b ack=%b expected 01/0", a_grant, a_m0_ack);
        end
        tick();
        @(negedge clk);
        checks++;
        if (a_grant !== 2'b00) begin errors++; $display("FAIL write_release: got %b expected 00", a_grant); end
    endtask

    task automatic test_alternation();
        logic [1:0] exp_g;
        apply_reset();
        m0_cyc = 1; m1_cyc = 1;
        @(negedge clk);
        checks++;
        if (a_grant !== 2'b00) begin errors++; $display("FAIL tie_wait: got %b expected 00", a_grant); end
        tick();
        @(negedge clk);
        checks++;
        if (a_grant !== 2'b01) begin errors++; $display("FAIL tie_first: got %b expected 01", a_grant); end
        tick();
        m0_cyc = 0;
        @(negedge clk);
        checks++;
        if (a_grant !== 2'b01) begin errors++; $display("FAIL handover_hold: got %b expected 01", a_grant); end
        tick();
        @(negedge clk);
        checks++;
        if (a_grant !== 2'b10) begin errors++; $display("FAIL handover_direct: got %b expected 10", a_grant); end
        tick();
        m1_cyc = 0;
        tick();
        @(negedge clk);
        checks++;
        if (a_grant !== 2'b00) begin errors++; $display("FAIL handover_idle: got %b expected 00", a_grant); end
        for (int k = 0; k < 4; k++) begin
            tick();
            m0_cyc = 1; m1_cyc = 1;
            @(negedge clk);
            checks++;
            if (a_grant !== 2'b00) begin errors++; $display("FAIL alt_idle_%0d: got %b expected 00", k, a_grant); end
            tick();
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge clk);
            checks++;
            if (a_grant !== exp_g) begin errors++; $display("FAIL alt_tie_%0d: got %b expected %b", k, a_grant, exp_g); end
            tick();
            m0_cyc = 0; m1_cyc = 0;
        end
        tick();
    endtask

    task automatic test_read_contention();
        apply_reset();
        m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 32'h2000; m1_sel = 4'hF;
        tick();
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h3000; m0_dat = 32'h55;
        s_ack = 1; s_dat_i = 32'h0000_3C11;
        @(negedge clk);
        checks++;
        if ({a_grant, a_m1_dat, a_m1_ack} !== {2'b10, 32'h3C11, 1'b1}) begin
            errors++; $display("FAIL read_m1: got grant=%b dat=%h ack=%b expected 10 00003c11 1", a_grant, a_m1_dat, a_m1_ack);
        end
        checks++;
        if ({a_m0_dat, a_m0_ack} !== 33'h0) begin
            errors++; $display("FAIL read_m0_blocked: got dat=%h ack=%b expected 0", a_m0_dat, a_m0_ack);
        end
        checks++;
        if ({a_s_we, a_s_adr} !== {1'b0, 32'h2000}) begin
            errors++; $display("FAIL read_route: got we=%b adr=%h expected 0 00002000", a_s_we, a_s_adr);
        end
        tick();
        m1_stb = 0; s_ack = 0;
        @(negedge clk);
        checks++;
        if ({a_grant, a_m0_dat, a_m0_ack, a_m1_ack} !== {2'b10, 34'h0}) begin
            errors++; $display("FAIL read_m0_wait: got grant=%b m0dat=%h m0ack=%b m1ack=%b expected 10 0 0 0",
                               a_grant, a_m0_dat, a_m0_ack, a_m1_ack);
        end
        tick();
        m1_cyc = 0;
        @(negedge clk);
        checks++;
        if ({a_grant, a_m0_dat} !== {2'b10, 32'h0}) begin
            errors++; $display("FAIL read_release_edge: got grant=%b m0dat=%h expected 10 0", a_grant, a_m0_dat);
        end
        tick();
        s_ack = 1;
        @(negedge clk);
        checks++;
        if ({a_grant, a_s_stb, a_s_we, a_s_adr, a_m0_ack} !== {2'b01, 2'b11, 32'h3000, 1'b1}) begin
            errors++; $display("FAIL read_m0_served: got grant=%b stb=%b we=%b adr=%h ack=%b expected 01 1 1 00003000 1",
                               a_grant, a_s_stb, a_s_we, a_s_adr, a_m0_ack);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_timeout();
        bit exp_e;
        apply_reset();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h4000;
        tick();
        for (int n = 1; n <= 40; n++) begin
            exp_e = (n == 16) || (n == 32);
            @(negedge clk);
            checks++;
            if ({a_m0_err, a_s_stb} !== {exp_e, ~exp_e}) begin
                errors++; $display("FAIL timeout_cycle_%0d: got err=%b stb=%b expected err=%b stb=%b",
                                   n, a_m0_err, a_s_stb, exp_e, ~exp_e);
            end
            checks++;
            if (b_m0_err !== 1'b0) begin errors++; $display("FAIL timeout_disabled_%0d: got err=%b expected 0", n, b_m0_err); end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_ack_on_16();
        int a_errs, b_errs, b_gaps;
        apply_reset();
        m0_cyc = 1; m0_stb = 1;
        tick();
        for (int n = 1; n <= 16; n++) begin
            s_ack = (n == 16);
            @(negedge clk);
            checks++;
            if ({a_m0_ack, a_m0_err} !== {(n == 16), 1'b0}) begin
                errors++; $display("FAIL ack16_cycle_%0d: got ack=%b err=%b expected ack=%b err=0",
                                   n, a_m0_ack, a_m0_err, (n == 16));
            end
            tick();
        end
        s_ack = 0;
        a_errs = 0; b_errs = 0; b_gaps = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (a_m0_err) a_errs++;
            if (b_m0_err) b_errs++;
            if (!b_s_stb) b_gaps++;
            tick();
        end
        checks++;
        if (b_errs != 0) begin errors++; $display("FAIL tmo0_no_err: got %0d err cycles expected 0", b_errs); end
        checks++;
        if (b_gaps != 0) begin errors++; $display("FAIL tmo0_stb: got %0d gated cycles expected 0", b_gaps); end
        checks++;
        if (a_errs != 6) begin errors++; $display("FAIL tmo16_count: got %0d err cycles expected 6", a_errs); end
        idle_inputs();
        tick();
    endtask

    task automatic test_async_reset();
        apply_reset();
        m1_cyc = 1; m1_stb = 1;
        tick();
        @(negedge clk);
        checks++;
        if ({a_grant, a_s_stb} !== 3'b101) begin
            errors++; $display("FAIL arst_owned: got grant=%b stb=%b expected 10 1", a_grant, a_s_stb);
        end
        #2;
        s_ack = 1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_s_cyc, a_s_stb, a_grant} !== 4'b0000) begin
            errors++; $display("FAIL arst_drop: got cyc=%b stb=%b grant=%b expected 0 0 00", a_s_cyc, a_s_stb, a_grant);
        end
        checks++;
        if ({a_m0_ack, a_m1_ack} !== 2'b00) begin
            errors++; $display("FAIL arst_no_ack: got m0=%b m1=%b expected 0 0", a_m0_ack, a_m1_ack);
        end
        tick();
        idle_inputs();
        tick();
        rst_n = 1'b1;
        m0_cyc = 1; m1_cyc = 1;
        tick();
        @(negedge clk);
        checks++;
        if (a_grant !== 2'b01) begin errors++; $display("FAIL arst_tie: got %b expected 01", a_grant); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_random(input int n);
        bit silent;
        int r;
        silent = 0;
        apply_reset();
        for (int i = 0; i < n; i++) begin
            if (i % 50 == 0) silent = ($urandom_range(2) == 0);
            if (!m0_cyc) m0_cyc = ($urandom_range(3) == 0);
            else if ($urandom_range(silent ? 60 : 6) == 0) m0_cyc = 0;
            if (!m1_cyc) m1_cyc = ($urandom_range(3) == 0);
            else if ($urandom_range(silent ? 60 : 6) == 0) m1_cyc = 0;
            m0_stb = m0_cyc && (silent || $urandom_range(3) != 0);
            m1_stb = m1_cyc && (silent || $urandom_range(3) != 0);
            m0_we = 1'($urandom); m0_adr = $urandom; m0_sel = 4'($urandom); m0_dat = $urandom;
            m1_we = 1'($urandom); m1_adr = $urandom; m1_sel = 4'($urandom); m1_dat = $urandom;
            s_dat_i = $urandom;
            r = silent ? 99 : int'($urandom_range(9));
            s_ack = (r < 5) || (r == 6);
            s_err = (r == 5) || (r == 6);
            s_rty = (r == 7);
            @(negedge clk);
            checks++;
            if (a_grant !== e_grant) begin errors++; $display("FAIL rnd_grant@%0d: got %b expected %b", i, a_grant, e_grant); end
            checks++;
            if ({a_s_cyc, a_s_stb, a_s_we, a_s_adr, a_s_sel, a_s_dat} !== {e_s_cyc, e_s_stb, e_s_we, e_s_adr, e_s_sel, e_s_dat}) begin
                errors++; $display("FAIL rnd_slave@%0d: got %b%b%b %h %h %h expected %b%b%b %h %h %h", i,
                                   a_s_cyc, a_s_stb, a_s_we, a_s_adr, a_s_sel, a_s_dat,
                                   e_s_cyc, e_s_stb, e_s_we, e_s_adr, e_s_sel, e_s_dat);
            end
            checks++;
            if ({a_m0_dat, a_m0_ack, a_m0_err, a_m0_rty} !== {e_dat[0], e_ack[0], e_err[0], e_rty[0]}) begin
                errors++; $display("FAIL rnd_m0@%0d: got %h %b%b%b expected %h %b%b%b", i,
                                   a_m0_dat, a_m0_ack, a_m0_err, a_m0_rty, e_dat[0], e_ack[0], e_err[0], e_rty[0]);
            end
            checks++;
            if ({a_m1_dat, a_m1_ack, a_m1_err, a_m1_rty} !== {e_dat[1], e_ack[1], e_err[1], e_rty[1]}) begin
                errors++; $display("FAIL rnd_m1@%0d: got %h %b%b%b expected %h %b%b%b", i,
                                   a_m1_dat, a_m1_ack, a_m1_err, a_m1_rty, e_dat[1], e_ack[1], e_err[1], e_rty[1]);
            end
            checks++;
            if ({b_m0_err, b_m1_err} !== {e_berr[0], e_berr[1]}) begin
                errors++; $display("FAIL rnd_tmo0_err@%0d: got %b%b expected %b%b", i, b_m0_err, b_m1_err, e_berr[0], e_berr[1]);
            end
            tick();
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_write();
        test_alternation();
        test_read_contention();
        test_timeout();
        test_ack_on_16();
        test_async_reset();
        test_random(2000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL sim_timeout: got no completion expected finish before 2000000");
        $fatal(1);
    end

endmodule
